// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational instruction memory,
// and keeps the fetched word in a one-entry IF/ID register that decode drains via valid/ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] address,
    input  logic [31:0] read_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4,
    output logic        halted,
    output logic        misalign_error,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_inst_pc4;
    logic        r_misalign;
    logic [31:0] r_count;
    logic [31:0] w_pc_plus4;
    logic        w_xfer;
    logic        w_load;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_xfer     = r_valid & inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_next;
    end

    // Redirect dominates every state; a halt word only stops fetch once it has been loaded.
    always_comb begin
        w_next = r_state;
        if (redirect_valid) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_BOOT:   w_next = S_FETCH;
                S_FETCH:  w_next = (w_load && read_data == HALT_WORD) ? S_HALTED : S_FETCH;
                S_HALTED: w_next = S_HALTED;
                default:  w_next = S_BOOT;
            endcase
        end
    end

    always_comb begin
        w_load = 1'b0;
        halted = 1'b0;
        case (r_state)
            S_FETCH:  w_load = !redirect_valid && (!r_valid || w_xfer);
            S_HALTED: halted = 1'b1;
            default:  w_load = 1'b0;
        endcase
    end

    // A transfer coinciding with a redirect still counts: decode already took the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_inst     <= 32'd0;
            r_inst_pc  <= 32'd0;
            r_inst_pc4 <= 32'd0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            if (w_xfer) r_count <= r_count + 32'd1;
            if (redirect_valid) begin
                r_pc    <= {redirect_target[31:2], 2'b00};
                r_valid <= 1'b0;
                if (|redirect_target[1:0]) r_misalign <= 1'b1;
            end else if (w_load) begin
                r_inst     <= read_data;
                r_inst_pc  <= r_pc;
                r_inst_pc4 <= w_pc_plus4;
                r_valid    <= 1'b1;
                r_pc       <= w_pc_plus4;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign address        = r_pc;
    assign inst_valid     = r_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_pc_plus4  = r_inst_pc4;
    assign misalign_error = r_misalign;
    assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues the words decode should receive,
// a negedge monitor pops and compares on every transfer; directed checks cover the rest.
module tb_fetch_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] read_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        halted;
    logic        misalign_error;
    logic [31:0] fetch_count;
    logic        halt_en;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .address(address), .read_data(read_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_ready(inst_ready), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4), .halted(halted),
        .misalign_error(misalign_error), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address a is C0DE_0000 + a; optional halt word at 16.
    always_comb begin
        if (halt_en && address == 32'd16)  read_data = HALT;
        else if (address < 32'd256)        read_data = 32'hC0DE_0000 + address;
        else                               read_data = 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word, input logic [31:0] pc);
        exp_t e;
        e.word = word;
        e.pc   = pc;
        sb_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0; halt_en = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && inst_valid && inst_ready) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected: got %h at pc %h expected no transfer", inst, inst_pc);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("sb_inst", inst, e.word);
                        chk("sb_pc", inst_pc, e.pc);
                        chk("sb_pc4", inst_pc_plus4, e.pc + 32'd4);
                    end
                end
            end
        join_none

        // Reset state
        #2;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_mis", 32'(misalign_error), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc4", inst_pc_plus4, 32'd0);
        step();
        rst = 1'b0;

        // Sequential fetch W0..W17
        inst_ready = 1'b1;
        for (int k = 0; k < 18; k++) push(32'hC0DE_0000 + 32'(4 * k), 32'(4 * k));
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 1) chk("boot_valid", 32'(inst_valid), 32'd0);
            if (i == 2) begin
                chk("first_valid", 32'(inst_valid), 32'd1);
                chk("first_inst", inst, 32'hC0DE_0000);
            end
        end
        inst_ready = 1'b0;
        chk("seq_count", fetch_count, 32'd18);
        chk("seq_next_pc", inst_pc, 32'd72);

        // Backpressure while W2 is held
        redirect_valid = 1'b1; redirect_target = 32'd0;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        push(32'hC0DE_0000, 32'd0);
        push(32'hC0DE_0004, 32'd4);
        push(32'hC0DE_0008, 32'd8);
        repeat (3) step();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_inst", inst, 32'hC0DE_0008);
            chk("bp_pc", inst_pc, 32'd8);
            chk("bp_addr", address, 32'd12);
            step();
        end
        chk("bp_inst_end", inst, 32'hC0DE_0008);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("bp_release_inst", inst, 32'hC0DE_000C);
        chk("bp_release_pc", inst_pc, 32'd12);
        chk("bp_count", fetch_count, 32'd21);

        // Redirect to 40 in the same cycle W1 is accepted
        redirect_valid = 1'b1; redirect_target = 32'd4;
        step();
        redirect_valid = 1'b0;
        step();
        chk("ra_w1_held", inst, 32'hC0DE_0004);
        push(32'hC0DE_0004, 32'd4);
        push(32'hC0DE_0028, 32'd40);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd40;
        step();
        redirect_valid = 1'b0;
        chk("ra_count", fetch_count, 32'd22);
        chk("ra_flush", 32'(inst_valid), 32'd0);
        chk("ra_addr", address, 32'd40);
        step();
        chk("ra_valid", 32'(inst_valid), 32'd1);
        chk("ra_inst", inst, 32'hC0DE_0028);
        chk("ra_pc", inst_pc, 32'd40);
        step();
        inst_ready = 1'b0;

        // Halt word at 16
        halt_en = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'd8;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b1;
        push(32'hC0DE_0008, 32'd8);
        push(32'hC0DE_000C, 32'd12);
        push(HALT, 32'd16);
        repeat (3) step();
        chk("halt_inst", inst, HALT);
        chk("halt_pc", inst_pc, 32'd16);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_addr", address, 32'd20);
        repeat (4) step();
        chk("halt_flag_hold", 32'(halted), 32'd1);
        chk("halt_addr_hold", address, 32'd20);
        chk("halt_drained", 32'(inst_valid), 32'd0);
        chk("halt_count", fetch_count, 32'd26);
        inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'd0;
        step();
        redirect_valid = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_addr", address, 32'd0);
        push(32'hC0DE_0000, 32'd0);
        step();
        chk("resume_inst", inst, 32'hC0DE_0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        halt_en = 1'b0;

        // Misaligned redirect and PC wrap
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("mis_addr", address, 32'hFFFF_FFFC);
        chk("mis_flag", 32'(misalign_error), 32'd1);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        step();
        chk("wrap_addr", address, 32'd0);
        chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", inst_pc_plus4, 32'd0);
        chk("wrap_inst", inst, 32'hDEAD_BEEF);
        push(32'hDEAD_BEEF, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap_count", fetch_count, 32'd28);
        chk("mis_sticky", 32'(misalign_error), 32'd1);

        // Asynchronous reset mid-stream at address 24
        redirect_valid = 1'b1; redirect_target = 32'd24;
        step();
        redirect_valid = 1'b0;
        chk("ar_pre_addr", address, 32'd24);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(inst_valid), 32'd0);
        chk("ar_addr", address, 32'd0);
        chk("ar_count", fetch_count, 32'd0);
        chk("ar_mis", 32'(misalign_error), 32'd0);
        chk("ar_halted", 32'(halted), 32'd0);
        #1 rst = 1'b0;
        step();
        chk("ar_boot_valid", 32'(inst_valid), 32'd0);
        step();
        chk("ar_first_valid", 32'(inst_valid), 32'd1);
        chk("ar_first_inst", inst, 32'hC0DE_0000);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
